// File: rtl/alu_result_fifo.sv
// Result buffer behind the ALU stage: stores {tag, data} pairs and hands them to the
// consumer in order. Writes arriving while full are dropped and latched in a sticky flag.
module alu_result_fifo #(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [TAG_W-1:0]           out_tag,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = TAG_W + DATA_W;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Handshake: a transfer happens on a rising edge where valid && ready. in_ready and
    // out_valid depend only on registered occupancy. The producer may hold in_valid
    // while in_ready=0; that beat is dropped and flagged, never stalled.

    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic            overflow_q;

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            drop;
    logic [EW-1:0]   head;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign push  = in_valid && !full;
    assign pop   = !empty && out_ready;
    assign drop  = in_valid && full;

    // Storage carries no reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= {in_tag, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // A drop in the same cycle as clr_ovf keeps the flag set.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem[rd_ptr];
        end
    end

    assign out_data  = head[DATA_W-1:0];
    assign out_tag   = head[EW-1:DATA_W];
    assign out_valid = !empty;
    assign in_ready  = !full;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: latency, fill/overflow, drain order, wrap and reset.
module tb_alu_result_fifo;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic [2:0] in_tag;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_tag;
    logic       out_ready;
    logic [2:0] count;
    logic       overflow;
    logic       clr_ovf;

    int total = 0;
    int bad   = 0;

    alu_result_fifo #(.DATA_W(8), .TAG_W(3), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [7:0] d, input logic [2:0] t);
        in_valid = v;
        in_data  = d;
        in_tag   = t;
    endtask

    initial begin
        logic [7:0] fill_d [4];
        logic [7:0] exp_d;
        fill_d[0] = 8'h11; fill_d[1] = 8'h22; fill_d[2] = 8'h33; fill_d[3] = 8'h44;

        rst_n = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        set_in(1'b0, 8'h00, 3'd0);
        #1;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_out_data",  32'(out_data),  32'h00);
        chk("rst_out_tag",   32'(out_tag),   32'd0);

        // Single push: nothing visible before the edge, head visible after it.
        set_in(1'b1, 8'h0C, 3'd0);
        #1;
        chk("no_fallthrough", 32'(out_valid), 32'd0);
        tick();
        set_in(1'b0, 8'h00, 3'd0);
        chk("push1_valid", 32'(out_valid), 32'd1);
        chk("push1_data",  32'(out_data),  32'h0C);
        chk("push1_tag",   32'(out_tag),   32'd0);
        chk("push1_count", 32'(count),     32'd1);
        tick();
        chk("hold_data", 32'(out_data), 32'h0C);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop1_count", 32'(count),     32'd0);
        chk("pop1_valid", 32'(out_valid), 32'd0);
        chk("pop1_data",  32'(out_data),  32'h00);

        // Pop on empty is harmless.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("empty_pop_count", 32'(count), 32'd0);

        // Fill to capacity with tags 1..4.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, fill_d[i], 3'(i + 1));
            tick();
        end
        set_in(1'b0, 8'h00, 3'd0);
        chk("fill_count",    32'(count),    32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_head",     32'(out_data), 32'h11);

        set_in(1'b1, 8'h55, 3'd5);
        tick();
        set_in(1'b0, 8'h00, 3'd0);
        chk("drop_overflow", 32'(overflow), 32'd1);
        chk("drop_count",    32'(count),    32'd4);
        chk("drop_head",     32'(out_data), 32'h11);

        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_overflow", 32'(overflow), 32'd0);

        // Drain in order; tag must travel with each data byte.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_data_%0d", i), 32'(out_data), 32'(fill_d[i]));
            chk($sformatf("drain_tag_%0d", i),  32'(out_tag),  32'(i + 1));
            tick();
        end
        out_ready = 1'b0;
        chk("drained_count", 32'(count),     32'd0);
        chk("drained_valid", 32'(out_valid), 32'd0);

        // Refill, then drop + pop + clr_ovf in one cycle.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 8'hA1 + 8'(i), 3'(i));
            tick();
        end
        set_in(1'b1, 8'h66, 3'd6);
        out_ready = 1'b1;
        clr_ovf   = 1'b1;
        tick();
        set_in(1'b0, 8'h00, 3'd0);
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        chk("dp_overflow", 32'(overflow), 32'd1);
        chk("dp_count",    32'(count),    32'd3);
        chk("dp_head",     32'(out_data), 32'hA2);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("dp_clr", 32'(overflow), 32'd0);

        // Drop one entry to leave A3, A4 queued (count=2).
        out_ready = 1'b1;
        tick();
        chk("pre_stream_count", 32'(count), 32'd2);

        // Ten cycles of simultaneous push and pop, wrapping both pointers.
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      exp_d = 8'hA3;
            else if (i == 1) exp_d = 8'hA4;
            else             exp_d = 8'(i - 2);
            chk($sformatf("stream_data_%0d", i), 32'(out_data), 32'(exp_d));
            set_in(1'b1, 8'(i), 3'(i));
            tick();
            chk($sformatf("stream_count_%0d", i), 32'(count), 32'd2);
        end
        set_in(1'b0, 8'h00, 3'd0);
        out_ready = 1'b0;
        chk("stream_tail_data", 32'(out_data), 32'h08);
        chk("stream_tail_tag",  32'(out_tag),  32'd0);

        // Build count=3, overflow=1, then reset with a push pending.
        set_in(1'b1, 8'h77, 3'd7); tick();
        set_in(1'b1, 8'h88, 3'd1); tick();
        set_in(1'b1, 8'h99, 3'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("prerst_count",    32'(count),    32'd3);
        chk("prerst_overflow", 32'(overflow), 32'd1);
        chk("prerst_head",     32'(out_data), 32'h09);

        rst_n = 1'b0;
        set_in(1'b1, 8'hEE, 3'd3);
        tick();
        rst_n = 1'b1;
        set_in(1'b0, 8'h00, 3'd0);
        chk("midrst_count",    32'(count),     32'd0);
        chk("midrst_valid",    32'(out_valid), 32'd0);
        chk("midrst_overflow", 32'(overflow),  32'd0);
        chk("midrst_in_ready", 32'(in_ready),  32'd1);
        chk("midrst_data",     32'(out_data),  32'h00);

        // Push into empty while the consumer is ready: only the push takes effect.
        set_in(1'b1, 8'h5A, 3'd4);
        out_ready = 1'b1;
        tick();
        set_in(1'b0, 8'h00, 3'd0);
        out_ready = 1'b0;
        chk("post_count", 32'(count),    32'd1);
        chk("post_data",  32'(out_data), 32'h5A);
        chk("post_tag",   32'(out_tag),  32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream buffer for the 4-bit ALU stage: captures each registered 8-bit ALU result plus its 3-bit opcode tag into a small FIFO.
- Presents results to the next consumer (readout/serializer logic) over a valid/ready handshake.
- The ALU produces results without backpressure, so the FIFO drops writes when full and records a sticky overflow flag.

Parameters:
- DATA_W, 8, result width (matches ALU result).
- TAG_W, 3, opcode tag width (matches ALU select).
- DEPTH, 4, number of entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  ALU result valid this cycle.
- in_data  input  DATA_W  ALU result.
- in_tag  input  TAG_W  opcode that produced in_data.
- in_ready  output  1  FIFO not full.
- out_valid  output  1  head entry available.
- out_data  output  DATA_W  head result.
- out_tag  output  TAG_W  head tag.
- out_ready  input  1  consumer accepts head this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: a write was dropped.
- clr_ovf  input  1  clears overflow.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - wr_ptr, rd_ptr and count go to 0; overflow goes to 0.
  - Storage contents are don't-care but are never visible.
  - Reset mid-operation discards all entries.
  - All requests in the reset cycle are ignored.
- Derived signals: full = (count==DEPTH); empty = (count==0); in_ready = !full; out_valid = !empty.
- Outputs out_valid, in_ready and count are functions of registered state only; there is no combinational path from in_* or out_ready.
- out_data/out_tag:
  - Equal mem[rd_ptr] when out_valid=1.
  - Forced to 0 when empty.
- Push:
  - Occurs when in_valid && !full; writes {in_tag,in_data} at wr_ptr, wr_ptr+1 mod DEPTH.
  - No fall-through: a push into an empty FIFO makes out_valid=1 on the following cycle (latency 1).
- Pop: occurs when out_valid && out_ready; rd_ptr+1 mod DEPTH.
- Simultaneous push and pop when 0<count<DEPTH: both happen and count is unchanged.
- Push attempted when full:
  - The entry is dropped and overflow is set, even if a pop happens in the same cycle.
  - count then decrements by the pop.
  - Already-stored entries are not modified.
- Pop with out_ready=1 when empty: no effect, and count never underflows.
- overflow:
  - Set by a dropped push; cleared by clr_ovf.
  - If a drop and clr_ovf occur in the same cycle, set wins and overflow stays 1.
- Pointers wrap modulo DEPTH.
- Ordering is strict FIFO; the tag always travels with its data.
- Single clock domain; no X may propagate to outputs after reset.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, count=0, overflow=0, out_data=0x00, out_tag=0.
- Push (tag=0, data=0x0C) in cycle N with out_ready=0:
  - out_valid=1, out_data=0x0C, out_tag=0 from cycle N+1; count=1.
  - Pop in N+2 -> count=0, out_valid=0 in N+3.
- Push 0x11,0x22,0x33,0x44 back-to-back with out_ready=0 -> count=4, in_ready=0.
  - Then push 0x55 -> dropped, overflow=1, count stays 4.
  - Drain -> 0x11,0x22,0x33,0x44 in order.
- Full FIFO with push 0x66 and pop in the same cycle:
  - Head popped, 0x66 dropped, overflow=1, count=3.
  - Also assert clr_ovf that cycle -> overflow stays 1.
  - clr_ovf alone next cycle -> overflow=0.
- Continuous push+pop for 10 cycles with count=2, data 0x00..0x09:
  - count stays 2.
  - Output sequence is the prior 2 entries then 0x00..0x07.
  - Pointers wrap correctly past DEPTH.
- Assert rst_n=0 for one cycle with count=3 and overflow=1 -> next cycle count=0, out_valid=0, overflow=0, in_ready=1.
